// File: rtl/configuration_register_bank_pkg.sv
// Shared constants and helpers for the configuration register bank.
package configuration_register_bank_pkg;

    localparam logic [1:0] MODE_RW     = 2'd0;
    localparam logic [1:0] MODE_RO     = 2'd1;
    localparam logic [1:0] MODE_W1C    = 2'd2;
    localparam logic [1:0] MODE_SHADOW = 2'd3;

    // Byte distance between consecutive registers.
    localparam int unsigned REG_STRIDE = 4;

    // Expand four byte-lane enables into a 32-bit bit mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] byte_select);
        logic [31:0] mask;
        mask = 32'h0000_0000;
        for (int n = 0; n < 4; n++) begin
            mask[n*8 +: 8] = byte_select[n] ? 8'hFF : 8'h00;
        end
        return mask;
    endfunction

endpackage

// File: rtl/configuration_register_bank_cell.sv
// One configuration register: RW, RO, W1C or shadowed RW with commit.
module config_register_cell
    import configuration_register_bank_pkg::*;
#(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [1:0]       MODE    = MODE_RW,
    parameter logic [WIDTH-1:0] DEFAULT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] wmask,
    input  logic [WIDTH-1:0] hw_value,
    input  logic [WIDTH-1:0] hw_set,
    input  logic             commit,
    output logic [WIDTH-1:0] active_value,
    output logic [WIDTH-1:0] read_value,
    output logic             write_strobe
);

    logic [WIDTH-1:0] active_d, active_q;
    logic [WIDTH-1:0] shadow_d, shadow_q;
    logic             strobe_d, strobe_q;
    logic [WIDTH-1:0] merged_s;
    logic [WIDTH-1:0] clear_s;

    // Depending on MODE some inputs have no effect on this instance.
    logic unused_sink;
    assign unused_sink = ^{hw_value, hw_set, commit, wdata, wmask, wr_en};

    // Next-state for the active value, shadow copy and write strobe.
    always_comb begin
        active_d = active_q;
        shadow_d = shadow_q;
        strobe_d = 1'b0;
        merged_s = (wdata & wmask) | (active_q & ~wmask);
        clear_s  = wr_en ? (wdata & wmask) : {WIDTH{1'b0}};
        case (MODE)
            MODE_RW: begin
                if (wr_en) begin
                    active_d = merged_s;
                    strobe_d = 1'b1;
                end else begin
                    active_d = active_q;
                end
            end
            MODE_RO: begin
                active_d = hw_value;
            end
            MODE_W1C: begin
                // Set is OR-ed in last so it wins over a clear of the same bit.
                active_d = (active_q & ~clear_s) | hw_set;
                strobe_d = wr_en;
            end
            MODE_SHADOW: begin
                // Commit uses the shadow as it stood before this cycle's write.
                if (commit) begin
                    active_d = shadow_q;
                end else begin
                    active_d = active_q;
                end
                if (wr_en) begin
                    shadow_d = (wdata & wmask) | (shadow_q & ~wmask);
                    strobe_d = 1'b1;
                end else begin
                    shadow_d = shadow_q;
                end
            end
            default: begin
                active_d = active_q;
            end
        endcase
    end

    // State registers with synchronous reset to the default value.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= DEFAULT;
            shadow_q <= DEFAULT;
            strobe_q <= 1'b0;
        end else begin
            active_q <= active_d;
            shadow_q <= shadow_d;
            strobe_q <= strobe_d;
        end
    end

    assign active_value = active_q;
    assign read_value   = (MODE == MODE_SHADOW) ? shadow_q : active_q;
    assign write_strobe = strobe_q;

endmodule

// File: rtl/configuration_register_bank.sv
// Bank of configuration registers behind one peripheral-bus slave port.
module configuration_register_bank
    import configuration_register_bank_pkg::*;
#(
    parameter int unsigned        COUNT        = 4,
    parameter int unsigned        WIDTH        = 32,
    parameter logic [11:0]        BASE_ADDRESS = 12'h000,
    parameter logic [COUNT*32-1:0] DEFAULTS    = '0,
    parameter logic [COUNT*2-1:0]  MODES       = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   peripheralBus_we,
    input  logic                   peripheralBus_oe,
    input  logic [11:0]            peripheralBus_address,
    input  logic [3:0]             peripheralBus_byteSelect,
    output logic [31:0]            peripheralBus_dataRead,
    input  logic [31:0]            peripheralBus_dataWrite,
    output logic                   requestOutput,
    input  logic [COUNT*WIDTH-1:0] hw_value,
    input  logic [COUNT*WIDTH-1:0] hw_set,
    input  logic                   commit,
    output logic [COUNT*WIDTH-1:0] current_value,
    output logic [COUNT-1:0]       write_strobe,
    output logic                   irq
);

    localparam logic [10:0] COUNT_L = 11'(COUNT);

    logic [11:0]      offset_s;
    logic [9:0]       reg_idx_s;
    logic             hit_s;
    logic             we_s;
    logic             oe_s;
    logic             we_accept_s;
    logic [31:0]      mask_full_s;
    logic [WIDTH-1:0] mask_s;
    logic [WIDTH-1:0] wdata_s;
    logic [WIDTH-1:0] read_sel_s;
    logic [31:0]      read_ext_s;
    logic [WIDTH-1:0] read_values_s [COUNT];
    logic [COUNT-1:0] irq_bits_s;

    // Bits above WIDTH on the write bus and in the mask are not stored.
    logic unused_sink;
    assign unused_sink = ^{peripheralBus_dataWrite, mask_full_s};

    // Address decode: word aligned, at or above the base, inside the bank.
    always_comb begin
        offset_s    = peripheralBus_address - BASE_ADDRESS;
        reg_idx_s   = offset_s[11:2];
        hit_s       = enable
                   && (peripheralBus_address[1:0] == 2'b00)
                   && (peripheralBus_address >= BASE_ADDRESS)
                   && ({1'b0, reg_idx_s} < COUNT_L);
        we_s        = hit_s && peripheralBus_we && !peripheralBus_oe;
        oe_s        = hit_s && peripheralBus_oe && !peripheralBus_we;
        we_accept_s = we_s && (peripheralBus_byteSelect != 4'b0000);
        mask_full_s = byte_mask(peripheralBus_byteSelect);
        mask_s      = mask_full_s[WIDTH-1:0];
        wdata_s     = peripheralBus_dataWrite[WIDTH-1:0];
    end

    genvar g;
    generate
        for (g = 0; g < COUNT; g++) begin : g_reg
            localparam logic [1:0] REG_MODE = MODES[2*g +: 2];
            logic [WIDTH-1:0] active_s;

            config_register_cell #(
                .WIDTH   (WIDTH),
                .MODE    (REG_MODE),
                .DEFAULT (DEFAULTS[32*g +: WIDTH])
            ) u_cell (
                .clk          (clk),
                .rst          (rst),
                .wr_en        (we_accept_s && (reg_idx_s == 10'(g))),
                .wdata        (wdata_s),
                .wmask        (mask_s),
                .hw_value     (hw_value[WIDTH*g +: WIDTH]),
                .hw_set       (hw_set[WIDTH*g +: WIDTH]),
                .commit       (commit),
                .active_value (active_s),
                .read_value   (read_values_s[g]),
                .write_strobe (write_strobe[g])
            );

            assign current_value[WIDTH*g +: WIDTH] = active_s;
            assign irq_bits_s[g] = (REG_MODE == MODE_W1C) ? (|active_s) : 1'b0;
        end
    endgenerate

    // Read mux: select the addressed register, zero-extend and lane-mask.
    always_comb begin
        read_sel_s = {WIDTH{1'b0}};
        for (int i = 0; i < COUNT; i++) begin
            read_sel_s = (reg_idx_s == 10'(i)) ? read_values_s[i] : read_sel_s;
        end
        read_ext_s              = 32'h0000_0000;
        read_ext_s[WIDTH-1:0]   = read_sel_s;
        peripheralBus_dataRead  = oe_s ? (read_ext_s & mask_full_s) : 32'h0000_0000;
        requestOutput           = oe_s;
    end

    assign irq = |irq_bits_s;

endmodule

// File: tb/tb_configuration_register_bank.sv
// Directed self-checking bench for configuration_register_bank.
module tb_configuration_register_bank;

    localparam int unsigned  COUNT = 4;
    localparam int unsigned  WIDTH = 32;
    localparam logic [127:0] DEFS  = {96'h0, 32'hA5A5_0000};
    localparam logic [7:0]   MODS  = {2'd3, 2'd2, 2'd1, 2'd0};

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         we;
    logic         oe;
    logic [11:0]  address;
    logic [3:0]   be;
    logic [31:0]  rdata;
    logic [31:0]  wdata;
    logic         req;
    logic [127:0] hw_value;
    logic [127:0] hw_set;
    logic         commit;
    logic [127:0] cur;
    logic [3:0]   strobe;
    logic         irq;

    int checks_total  = 0;
    int checks_passed = 0;

    configuration_register_bank #(
        .COUNT        (COUNT),
        .WIDTH        (WIDTH),
        .BASE_ADDRESS (12'h100),
        .DEFAULTS     (DEFS),
        .MODES        (MODS)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .enable                   (enable),
        .peripheralBus_we         (we),
        .peripheralBus_oe         (oe),
        .peripheralBus_address    (address),
        .peripheralBus_byteSelect (be),
        .peripheralBus_dataRead   (rdata),
        .peripheralBus_dataWrite  (wdata),
        .requestOutput            (req),
        .hw_value                 (hw_value),
        .hw_set                   (hw_set),
        .commit                   (commit),
        .current_value            (cur),
        .write_strobe             (strobe),
        .irq                      (irq)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        enable = 1'b0;
        we     = 1'b0;
        oe     = 1'b0;
        be     = 4'h0;
        wdata  = 32'h0;
        commit = 1'b0;
        hw_set = 128'h0;
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
        enable  = 1'b1;
        we      = 1'b1;
        oe      = 1'b0;
        address = a;
        wdata   = d;
        be      = b;
    endtask

    task automatic bus_read(input logic [11:0] a);
        enable  = 1'b1;
        we      = 1'b0;
        oe      = 1'b1;
        address = a;
        be      = 4'hF;
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        address  = 12'h000;
        hw_value = 128'h0;
        bus_idle();
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_value("rst_cv0", cur[31:0], 32'hA5A5_0000);
        check_value("rst_irq", {31'h0, irq}, 32'h0);
        check_value("rst_strobe", {28'h0, strobe}, 32'h0);
        bus_read(12'h100);
        check_value("rst_read0", rdata, 32'hA5A5_0000);
        check_value("rst_req0", {31'h0, req}, 32'h1);
        tick();

        // RW partial write
        bus_write(12'h100, 32'h1234_5678, 4'b0101);
        tick();
        bus_idle();
        check_value("rw_cv0", cur[31:0], 32'hA534_0078);
        check_value("rw_strobe", {28'h0, strobe}, 32'h1);
        tick();
        check_value("rw_strobe_end", {28'h0, strobe}, 32'h0);

        // RO: sampled status, bus write ignored
        hw_value[63:32] = 32'hDEAD_BEEF;
        tick();
        bus_write(12'h104, 32'hFFFF_FFFF, 4'hF);
        tick();
        bus_idle();
        check_value("ro_cv1", cur[63:32], 32'hDEAD_BEEF);
        check_value("ro_strobe", {28'h0, strobe}, 32'h0);
        bus_read(12'h104);
        check_value("ro_read1", rdata, 32'hDEAD_BEEF);
        tick();
        bus_idle();

        // W1C: set raises irq, set beats clear, clear drops irq
        hw_set[95:64] = 32'h0000_0009;
        tick();
        hw_set = 128'h0;
        check_value("w1c_irq_set", {31'h0, irq}, 32'h1);
        check_value("w1c_cv2_set", cur[95:64], 32'h0000_0009);
        bus_write(12'h108, 32'h1, 4'hF);
        hw_set[95:64] = 32'h0000_0001;
        tick();
        bus_idle();
        check_value("w1c_set_wins", cur[95:64], 32'h0000_0009);
        check_value("w1c_strobe", {28'h0, strobe}, 32'h4);
        bus_write(12'h108, 32'h9, 4'hF);
        tick();
        bus_idle();
        check_value("w1c_cleared", cur[95:64], 32'h0);
        check_value("w1c_irq_clr", {31'h0, irq}, 32'h0);

        // SHADOW: write lands in shadow, commit applies it
        bus_write(12'h10C, 32'h55, 4'hF);
        tick();
        bus_idle();
        check_value("sh_strobe", {28'h0, strobe}, 32'h8);
        bus_read(12'h10C);
        check_value("sh_read", rdata, 32'h55);
        check_value("sh_cv3_pre", cur[127:96], 32'h0);
        tick();
        bus_idle();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check_value("sh_commit", cur[127:96], 32'h55);
        bus_write(12'h10C, 32'h66, 4'hF);
        commit = 1'b1;
        tick();
        bus_idle();
        check_value("sh_same_cyc", cur[127:96], 32'h55);
        bus_read(12'h10C);
        check_value("sh_read66", rdata, 32'h66);
        tick();
        bus_idle();

        // Back-to-back writes give back-to-back strobes
        bus_write(12'h100, 32'h0000_0001, 4'b0001);
        tick();
        check_value("b2b_strobe1", {28'h0, strobe}, 32'h1);
        bus_write(12'h100, 32'h0000_0078, 4'b0001);
        tick();
        bus_idle();
        check_value("b2b_strobe2", {28'h0, strobe}, 32'h1);
        check_value("b2b_cv0", cur[31:0], 32'hA534_0078);

        // Zero byteSelect: no change, no strobe
        bus_write(12'h100, 32'hFFFF_FFFF, 4'h0);
        tick();
        bus_idle();
        check_value("be0_strobe", {28'h0, strobe}, 32'h0);
        check_value("be0_cv0", cur[31:0], 32'hA534_0078);

        // Unmapped, misaligned and conflicting accesses
        bus_read(12'h110);
        check_value("unmap_req", {31'h0, req}, 32'h0);
        check_value("unmap_data", rdata, 32'h0);
        bus_read(12'h102);
        check_value("misal_req", {31'h0, req}, 32'h0);
        check_value("misal_data", rdata, 32'h0);
        bus_read(12'h0FC);
        check_value("below_req", {31'h0, req}, 32'h0);
        bus_write(12'h100, 32'hFFFF_FFFF, 4'hF);
        oe = 1'b1;
        #1;
        check_value("weoe_req", {31'h0, req}, 32'h0);
        check_value("weoe_data", rdata, 32'h0);
        tick();
        bus_write(12'h102, 32'hFFFF_FFFF, 4'hF);
        tick();
        bus_idle();
        check_value("weoe_cv0", cur[31:0], 32'hA534_0078);
        check_value("weoe_strobe", {28'h0, strobe}, 32'h0);
        tick();
        check_value("misal_cv0", cur[31:0], 32'hA534_0078);

        // Reset wins over a simultaneous write
        bus_write(12'h100, 32'h0, 4'hF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_idle();
        check_value("rst_prio_cv0", cur[31:0], 32'hA5A5_0000);
        check_value("rst_prio_cv3", cur[127:96], 32'h0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
